// File: rtl/monishvr_fifo.sv
`default_nettype none
// ============================================================================
// Module      : monishvr_fifo
// Description : Tiny Tapeout tile top: 16x4 synchronous FIFO with registered
//               read data, full/empty, sticky overflow/underflow and fill count.
// Revision    : 1.0 - initial release
// ============================================================================
module monishvr_fifo #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int               c_ADDR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] c_FULL   = CNT_W'(DEPTH);

    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [c_ADDR_W-1:0] r_wp;
    logic [c_ADDR_W-1:0] r_rp;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_dout;
    logic                r_overflow;
    logic                r_underflow;

    logic w_full;
    logic w_empty;
    logic w_wr_en;
    logic w_rd_en;
    logic w_ra;
    logic w_wa;
    logic w_unused;

    assign w_full  = (r_cnt == c_FULL);
    assign w_empty = (r_cnt == '0);
    assign w_wr_en = ena & ui_in[4];
    assign w_rd_en = ena & ui_in[5];

    // A read at full frees a slot, so a simultaneous write is still accepted.
    assign w_ra = w_rd_en & ~w_empty;
    assign w_wa = w_wr_en & (~w_full | w_ra);

    assign w_unused = ^{uio_in, ui_in[7:6]};

    always_ff @(posedge clk) begin
        if (w_wa && !rst) begin
            r_mem[r_wp] <= ui_in[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp        <= '0;
            r_rp        <= '0;
            r_cnt       <= '0;
            r_dout      <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wa) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_ra) begin
                r_dout <= r_mem[r_rp];
                r_rp   <= r_rp + 1'b1;
            end
            if (w_wa && !w_ra) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (w_ra && !w_wa) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_wr_en && !w_wa) begin
                r_overflow <= 1'b1;
            end
            if (w_rd_en && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign uo_out  = {r_underflow, r_overflow, w_empty, w_full, r_dout};
    assign uio_out = {{(8 - CNT_W){1'b0}}, r_cnt};
    assign uio_oe  = 8'hFF;

endmodule
`default_nettype wire

// File: tb/tb_monishvr_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_monishvr_fifo
// Description : Directed self-checking bench for monishvr_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_monishvr_fifo;

    logic       clk;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_pass;
    int n_checks;

    monishvr_fifo #(
        .DATA_W(4),
        .DEPTH (16),
        .CNT_W (5)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .ena    (ena),
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input logic w, input logic r, input logic [3:0] d);
        ui_in = {2'b00, r, w, d};
        @(posedge clk);
        @(negedge clk);
        ui_in = 8'h00;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        n_pass   = 0;
        n_checks = 0;
        rst      = 1'b1;
        ena      = 1'b1;
        ui_in    = 8'h00;
        uio_in   = 8'hA5;
        @(negedge clk);

        // reset wins over strobes
        cyc(1'b1, 1'b1, 4'h5);
        cyc(1'b1, 1'b0, 4'h3);
        rst = 1'b0;
        check("reset_uo", uo_out, 8'h20);
        check("reset_cnt", uio_out, 8'h00);
        check("uio_oe", uio_oe, 8'hFF);

        // basic write/read
        cyc(1'b1, 1'b0, 4'h1);
        cyc(1'b1, 1'b0, 4'h2);
        cyc(1'b1, 1'b0, 4'h3);
        check("wr3_uo", uo_out, 8'h00);
        check("wr3_cnt", uio_out, 8'h03);
        cyc(1'b0, 1'b1, 4'h0);
        check("rd1_uo", uo_out, 8'h01);
        check("rd1_cnt", uio_out, 8'h02);
        cyc(1'b0, 1'b1, 4'h0);
        check("rd2_uo", uo_out, 8'h02);
        cyc(1'b0, 1'b1, 4'h0);
        check("rd3_uo", uo_out, 8'h23);
        check("rd3_cnt", uio_out, 8'h00);

        // fill and overflow
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 4'(i));
        check("fill_uo", uo_out, 8'h13);
        check("fill_cnt", uio_out, 8'h10);
        cyc(1'b1, 1'b0, 4'h9);
        check("ovf_uo", uo_out, 8'h53);
        check("ovf_cnt", uio_out, 8'h10);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, 4'h0);
            check("drain_data", {4'h0, uo_out[3:0]}, 8'(i));
        end
        check("drain_uo", uo_out, 8'h6F);
        check("drain_cnt", uio_out, 8'h00);

        // simultaneous read/write at full
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 4'(i));
        cyc(1'b1, 1'b1, 4'h5);
        check("fullrw_uo", uo_out, 8'h50);
        check("fullrw_cnt", uio_out, 8'h10);
        for (int i = 1; i < 16; i++) begin
            cyc(1'b0, 1'b1, 4'h0);
            check("fullrw_drain", {4'h0, uo_out[3:0]}, 8'(i));
        end
        cyc(1'b0, 1'b1, 4'h0);
        check("fullrw_last", uo_out, 8'h65);

        // underflow and simultaneous read/write on empty
        cyc(1'b0, 1'b1, 4'h0);
        check("udf_uo", uo_out, 8'hE5);
        cyc(1'b1, 1'b1, 4'h7);
        check("emptyrw_uo", uo_out, 8'hC5);
        check("emptyrw_cnt", uio_out, 8'h01);
        cyc(1'b0, 1'b1, 4'h0);
        check("emptyrw_rd", uo_out, 8'hE7);

        // reset mid-operation discards contents and clears sticky flags
        cyc(1'b1, 1'b0, 4'hC);
        cyc(1'b1, 1'b0, 4'hD);
        rst = 1'b1;
        cyc(1'b0, 1'b0, 4'h0);
        rst = 1'b0;
        check("midrst_uo", uo_out, 8'h20);
        check("midrst_cnt", uio_out, 8'h00);
        cyc(1'b0, 1'b1, 4'h0);
        check("midrst_rd", uo_out, 8'hA0);
        rst = 1'b1;
        cyc(1'b0, 1'b0, 4'h0);
        rst = 1'b0;

        // pointer wrap with one word in flight
        cyc(1'b1, 1'b0, 4'hA);
        for (int i = 1; i <= 20; i++) begin
            cyc(1'b1, 1'b1, 4'(i));
            check("wrap_data", {4'h0, uo_out[3:0]}, (i == 1) ? 8'h0A : 8'((i - 1) % 16));
        end
        check("wrap_cnt", uio_out, 8'h01);
        cyc(1'b0, 1'b1, 4'h0);
        check("wrap_last", uo_out, 8'h24);

        // enable low freezes everything
        ena = 1'b0;
        cyc(1'b1, 1'b0, 4'h3);
        cyc(1'b0, 1'b1, 4'h0);
        cyc(1'b1, 1'b1, 4'h6);
        check("ena_uo", uo_out, 8'h24);
        check("ena_cnt", uio_out, 8'h00);
        ena = 1'b1;
        cyc(1'b1, 1'b0, 4'hB);
        check("ena_back_cnt", uio_out, 8'h01);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/monishvr_fifo.md
# monishvr_fifo

Synchronous first-in/first-out buffer packaged as a Tiny Tapeout user tile. Write data, write/read strobes and a data path map onto the tile's dedicated 8-bit input and output pins. The block stores up to DEPTH words of DATA_W bits and reports full/empty status, sticky overflow/underflow errors and the current fill level. It is the top of the tile; no other logic sits between it and the pads.

## Interface
Parameters:
- DATA_W, 4, word width; fixed to fit the pin map.
- DEPTH, 16, number of storage entries; must be a power of two.
- CNT_W, 5, fill-count width, log2(DEPTH)+1.

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- ena  input  1  tile enable; when low, write and read strobes are ignored and all state holds.
- ui_in  input  8  [3:0] write data, [4] wr_en, [5] rd_en, [7:6] unused.
- uo_out  output  8  [3:0] read data register, [4] full, [5] empty, [6] overflow (sticky), [7] underflow (sticky).
- uio_in  input  8  unused; ignored.
- uio_out  output  8  [4:0] fill count, [7:5] = 0.
- uio_oe  output  8  constant 8'hFF.

## Operation
- Storage: DEPTH x DATA_W register array, write pointer wp, read pointer rp (log2(DEPTH) bits each, natural wrap), count register cnt (0..DEPTH).
- full = (cnt == DEPTH); empty = (cnt == 0); both are combinational from cnt.
- Accepted write (wa) = ena & wr_en & (!full | ra). On wa: mem[wp] <= ui_in[3:0], wp <= wp+1.
- Accepted read (ra) = ena & rd_en & !empty. On ra: dout <= mem[rp], rp <= rp+1.
- cnt: +1 if wa & !ra; -1 if ra & !wa; unchanged otherwise.
- Simultaneous wr_en & rd_en:
  - Normal case: both are accepted and cnt is unchanged.
  - When full: both are accepted. The read returns the oldest entry and the write fills the freed slot. Full stays asserted.
  - When empty: only the write is accepted, the read is rejected, dout holds, and underflow is set.
- Rejected write (ena & wr_en & full & !ra): memory and pointers are untouched and the overflow flag is set.
- Rejected read (ena & rd_en & empty): dout holds and the underflow flag is set.
- overflow and underflow stay set until reset.
- dout holds its value between reads. Read data is never combinational from memory.
- Strobes are level-sensitive: each cycle a strobe is high performs one operation.

## Timing
- Reset (rst high at a rising edge): wp = rp = 0, cnt = 0, dout = 0, overflow = underflow = 0.
  - Outputs after reset: uo_out = 8'h20 (empty only), uio_out = 0.
  - Memory contents are not reset.
  - Reset has priority over any strobe in the same cycle.
  - A reset asserted mid-operation discards all stored data.
- Write latency: the data is stored at the edge where wa is evaluated true. Flags and count reflect it after that same edge.
- Read latency: one cycle. uo_out[3:0] shows the popped word after the edge where ra is evaluated true.
- A word written at edge N can be read by a read strobe sampled at edge N+1. Its data appears after edge N+1.
- Pointer wrap from DEPTH-1 to 0 is seamless. Ordering is preserved across wrap.

## Test plan
- Reset: hold rst high for 2 cycles with strobes toggling -> uo_out = 8'h20, uio_out = 8'h00.
- Write 1,2,3 on consecutive cycles, then read 3 cycles -> uo_out[3:0] shows 1, 2, 3 on successive cycles; count goes 3->0; empty is reasserted.
- Fill to 16 entries (values 0..15), then issue one more write of 9 -> full = 1, overflow = 1, count = 16. Drain 16 reads -> 0..15 in order, and 9 is never returned.
- At full, assert wr_en and rd_en together with data 5 -> dout = oldest word, count stays 16. After a full drain, 5 is the last word out.
- Read on empty -> underflow = 1, dout unchanged. Simultaneous wr/rd on empty with data 7 -> count = 1, and the next read returns 7.
- Wrap and enable: do 20 writes interleaved with reads so the pointers wrap, and check FIFO order. Drive strobes with ena = 0 -> no state change.
